// File: rtl/pa_fpu_pkg.sv
// pa_fpu: shared definitions for the FPU host port.
//   - fpu_op_e      : arithmetic opcodes carried on core_op
//   - REG_*         : host register addresses (compared against a zero-extended address)
//   - ST_*          : bit positions inside the status byte
//   - host_state_e  : host-interface FSM states
//   - QNAN          : result reported when the core times out
package pa_fpu;

    typedef enum logic [3:0] {
        op_add = 4'd0,
        op_sub = 4'd1,
        op_mul = 4'd2,
        op_div = 4'd3
    } fpu_op_e;

    localparam logic [31:0] REG_A0     = 32'h00;
    localparam logic [31:0] REG_B0     = 32'h04;
    localparam logic [31:0] REG_CMD    = 32'h08;
    localparam logic [31:0] REG_RES0   = 32'h09;
    localparam logic [31:0] REG_STATUS = 32'h0D;

    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_CMD_END  = 1;
    localparam int unsigned ST_ERR_BUSY = 2;
    localparam int unsigned ST_ERR_TO   = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } host_state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_host_if.sv
// fpu_host_if: bus-side responder for the FPU's 8-bit host port.
//   Assembles operands A/B from byte writes, launches the core on a command
//   write, waits for core_done (or times out), and serves result/status reads.
// Ports:
//   clk, arst (async, active-low)
//   databus_in / databus_out  host write data / registered read data
//   addr, cs, rd, wr          register address and active-low strobes
//   end_ack                   host acknowledge of cmd_end
//   cmd_end, busy             completion flag (level until acked), op in progress
//   core_start/op/a/b         launch pulse, opcode and operands to the core
//   core_done/core_result     completion pulse and result from the core
module fpu_host_if
    import pa_fpu::*;
#(
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 8,
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] databus_in,
    output logic [DATA_W-1:0] databus_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic              end_ack,
    output logic              cmd_end,
    output logic              busy,
    output logic              core_start,
    output logic [OP_W-1:0]   core_op,
    output logic [31:0]       core_a,
    output logic [31:0]       core_b,
    input  logic              core_done,
    input  logic [31:0]       core_result
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    host_state_e      state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      result;
    logic             err_to, err_busy;
    logic             wr_q;
    logic [31:0]      addr_u;
    logic             wr_act, rd_act, wr_commit;
    logic             op_wr, cmd_wr, cmd_accept;
    logic [7:0]       rd_byte;
    logic [7:0]       status_byte;

    assign addr_u = 32'(addr);
    assign wr_act = !cs && !wr;
    assign rd_act = !cs && !rd;

    // One commit per write pulse: only the first cycle of a held strobe counts.
    assign wr_commit  = wr_act && !wr_q;
    assign op_wr      = wr_commit && (addr_u < REG_CMD);
    assign cmd_wr     = wr_commit && (addr_u == REG_CMD);
    assign cmd_accept = cmd_wr && !busy;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (cmd_accept) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT:  if (core_done || cnt == CNT_LAST) state_nx = S_DONE;
            // A command in DONE acts as an implicit ack and wins over end_ack.
            S_DONE: begin
                if (cmd_accept)   state_nx = S_START;
                else if (end_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state == S_START) || (state == S_WAIT);
        cmd_end    = (state == S_DONE);
        core_start = (state == S_START);
    end

    // ---------------- register file, counter, result ----------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_q     <= 1'b0;
            core_a   <= '0;
            core_b   <= '0;
            core_op  <= '0;
            result   <= '0;
            err_to   <= 1'b0;
            err_busy <= 1'b0;
            cnt      <= '0;
        end else begin
            wr_q <= wr_act;

            if (op_wr && !busy) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (addr_u == REG_A0 + i) core_a[8*i +: 8] <= databus_in[7:0];
                    if (addr_u == REG_B0 + i) core_b[8*i +: 8] <= databus_in[7:0];
                end
            end

            if ((op_wr || cmd_wr) && busy) err_busy <= 1'b1;

            if (cmd_accept) begin
                core_op  <= databus_in[OP_W-1:0];
                err_busy <= 1'b0;
                err_to   <= 1'b0;
            end

            if (state == S_START) cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + 1'b1;

            // core_done takes priority over a timeout landing on the same cycle.
            if (state == S_WAIT) begin
                if (core_done) begin
                    result <= core_result;
                end else if (cnt == CNT_LAST) begin
                    result <= QNAN;
                    err_to <= 1'b1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        status_byte              = '0;
        status_byte[ST_BUSY]     = busy;
        status_byte[ST_CMD_END]  = cmd_end;
        status_byte[ST_ERR_BUSY] = err_busy;
        status_byte[ST_ERR_TO]   = err_to;
    end

    always_comb begin
        rd_byte = '0;
        unique case (addr_u)
            REG_A0:       rd_byte = core_a[7:0];
            REG_A0 + 1:   rd_byte = core_a[15:8];
            REG_A0 + 2:   rd_byte = core_a[23:16];
            REG_A0 + 3:   rd_byte = core_a[31:24];
            REG_B0:       rd_byte = core_b[7:0];
            REG_B0 + 1:   rd_byte = core_b[15:8];
            REG_B0 + 2:   rd_byte = core_b[23:16];
            REG_B0 + 3:   rd_byte = core_b[31:24];
            REG_CMD:      rd_byte = 8'(core_op);
            REG_RES0:     rd_byte = result[7:0];
            REG_RES0 + 1: rd_byte = result[15:8];
            REG_RES0 + 2: rd_byte = result[23:16];
            REG_RES0 + 3: rd_byte = result[31:24];
            REG_STATUS:   rd_byte = status_byte;
            default:      rd_byte = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)       databus_out <= '0;
        else if (rd_act) databus_out <= DATA_W'(rd_byte);
        else             databus_out <= '0;
    end

endmodule

// File: tb/tb_fpu_host_if.sv
module tb_fpu_host_if;
    import pa_fpu::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  databus_in = '0;
    logic [7:0]  databus_out;
    logic [5:0]  addr = '0;
    logic        cs = 1'b1, rd = 1'b1, wr = 1'b1;
    logic        end_ack = 1'b0;
    logic        cmd_end, busy, core_start;
    logic [3:0]  core_op;
    logic [31:0] core_a, core_b;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;

    always #5 clk = ~clk;

    fpu_host_if #(
        .ADDR_W(6),
        .DATA_W(8),
        .OP_W(4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .arst(arst),
        .databus_in(databus_in),
        .databus_out(databus_out),
        .addr(addr),
        .cs(cs),
        .rd(rd),
        .wr(wr),
        .end_ack(end_ack),
        .cmd_end(cmd_end),
        .busy(busy),
        .core_start(core_start),
        .core_op(core_op),
        .core_a(core_a),
        .core_b(core_b),
        .core_done(core_done),
        .core_result(core_result)
    );

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the host port ----------------
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_op = '0;
    bit          m_start = 0, m_busy = 0, m_end = 0, m_eto = 0, m_ebusy = 0, m_prev_wr = 0;
    int          m_wait = 0;
    logic [7:0]  m_dout = '0;

    function automatic logic [7:0] m_byte(input logic [5:0] a);
        int ai;
        ai = int'(a);
        if (ai < 4)        return 8'(m_a >> (8*ai));
        else if (ai < 8)   return 8'(m_b >> (8*(ai-4)));
        else if (ai == 8)  return {4'b0, m_op};
        else if (ai <= 12) return 8'(m_res >> (8*(ai-9)));
        else if (ai == 13) return {4'b0, m_eto, m_ebusy, m_end, m_busy};
        else               return 8'h00;
    endfunction

    initial begin : model
        bit wr_now, commit, was_start, was_wait, was_end, accept;
        int ai;
        forever begin
            @(posedge clk or negedge arst);
            if (!arst) begin
                m_a = '0; m_b = '0; m_res = '0; m_op = '0;
                m_start = 0; m_busy = 0; m_end = 0; m_eto = 0; m_ebusy = 0;
                m_prev_wr = 0; m_wait = 0; m_dout = '0;
            end else begin
                m_dout = (!cs && !rd) ? m_byte(addr) : 8'h00;
                wr_now = !cs && !wr;
                commit = wr_now && !m_prev_wr;
                m_prev_wr = wr_now;
                was_start = m_start;
                was_wait  = m_busy && !m_start;
                was_end   = m_end;
                accept    = 0;
                ai = int'(addr);
                if (commit && ai <= 8) begin
                    if (m_busy)      m_ebusy = 1;
                    else if (ai < 4) m_a[8*ai +: 8] = databus_in;
                    else if (ai < 8) m_b[8*(ai-4) +: 8] = databus_in;
                    else begin
                        accept = 1; m_op = databus_in[3:0]; m_ebusy = 0; m_eto = 0;
                    end
                end
                if (accept) begin
                    m_start = 1; m_busy = 1; m_end = 0;
                end else if (was_start) begin
                    m_start = 0; m_wait = 0;
                end else if (was_wait) begin
                    if (core_done) begin
                        m_res = core_result; m_busy = 0; m_end = 1;
                    end else if (m_wait == T-1) begin
                        m_res = QNAN; m_eto = 1; m_busy = 0; m_end = 1;
                    end else begin
                        m_wait++;
                    end
                end else if (was_end && end_ack) begin
                    m_end = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("busy", busy, m_busy);
                check("cmd_end", cmd_end, m_end);
                check("core_start", core_start, m_start);
                check("core_a", core_a, m_a);
                check("core_b", core_b, m_b);
                check("core_op", core_op, m_op);
                check("databus_out", databus_out, m_dout);
            end
        end
    end

    // ---------------- core model and start counter ----------------
    bit          core_respond = 0;
    int          core_lat = 1;
    logic [31:0] core_resp = '0;
    int          starts = 0;

    initial begin : core_model
        forever begin
            @(negedge clk);
            if (arst && core_start && core_respond) begin
                repeat (core_lat) @(posedge clk);
                #2 core_done = 1'b1; core_result = core_resp;
                @(posedge clk);
                #2 core_done = 1'b0;
            end
        end
    end

    initial begin : start_count
        forever begin
            @(negedge clk);
            if (core_start) starts++;
        end
    end

    // ---------------- host bus tasks ----------------
    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk);
        #2 cs = 1'b0; wr = 1'b0; addr = a; databus_in = d;
        @(posedge clk);
        #2 cs = 1'b1; wr = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [5:0] a, input logic [7:0] exp);
        logic [7:0] d;
        @(posedge clk);
        #2 cs = 1'b0; rd = 1'b0; addr = a;
        @(posedge clk);
        #1 d = databus_out;
        #1 cs = 1'b1; rd = 1'b1;
        check(name, d, exp);
    endtask

    task automatic wait_end(input string name, input int maxc);
        int n;
        n = 0;
        while (!cmd_end && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, cmd_end, 1);
    endtask

    task automatic ack();
        @(posedge clk);
        #2 end_ack = 1'b1;
        @(posedge clk);
        #2 end_ack = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int s0, n, w;
        #1 arst = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_cmd_end", cmd_end, 0);
        check("rst_core_start", core_start, 0);
        check("rst_dout", databus_out, 0);
        #1 arst = 1'b1;
        read_chk("rst_status", 6'h0D, 8'h00);

        // 1: 177.88 / 99.99
        core_respond = 1; core_lat = 3; core_resp = 32'h3FE3_B58C;
        host_write(6'h00, 8'h48); host_write(6'h01, 8'hE1);
        host_write(6'h02, 8'h31); host_write(6'h03, 8'h43);
        host_write(6'h04, 8'hE1); host_write(6'h05, 8'hFA);
        host_write(6'h06, 8'hC7); host_write(6'h07, 8'h42);
        s0 = starts;
        host_write(6'h08, 8'(op_div));
        check("t1_busy", busy, 1);
        wait_end("t1_done", 100);
        check("t1_one_start", starts - s0, 1);
        check("t1_core_a", core_a, 32'h4331_E148);
        check("t1_core_b", core_b, 32'h42C7_FAE1);
        check("t1_core_op", core_op, 4'd3);
        read_chk("t1_res0", 6'h09, 8'h8C);
        read_chk("t1_res1", 6'h0A, 8'hB5);
        read_chk("t1_res2", 6'h0B, 8'hE3);
        read_chk("t1_res3", 6'h0C, 8'h3F);
        read_chk("t1_status", 6'h0D, 8'h02);
        read_chk("t1_read_a3", 6'h03, 8'h43);

        // 2: ack, then back-to-back command in DONE
        ack();
        @(negedge clk);
        check("t2_ack_cmd_end", cmd_end, 0);
        read_chk("t2_status", 6'h0D, 8'h00);
        core_resp = 32'h1234_5678;
        host_write(6'h08, 8'(op_mul));
        wait_end("t2_done", 100);
        s0 = starts;
        host_write(6'h08, 8'(op_add));
        check("t2_implicit_ack", cmd_end, 0);
        @(negedge clk);
        check("t2_new_start", starts - s0, 1);
        wait_end("t2_done2", 100);
        read_chk("t2_res3", 6'h0C, 8'h12);

        // 3: writes while busy are rejected
        core_respond = 0;
        host_write(6'h08, 8'(op_sub));
        host_write(6'h03, 8'hAA);
        host_write(6'h08, 8'(op_add));
        check("t3_core_a", core_a, 32'h4331_E148);
        check("t3_core_op", core_op, 4'd1);
        read_chk("t3_status", 6'h0D, 8'h05);
        wait_end("t3_timeout", 100);
        read_chk("t3_status_done", 6'h0D, 8'h0E);
        ack();

        // 4: timeout after exactly T wait cycles
        host_write(6'h08, 8'(op_div));
        n = 0; w = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy && !core_start) w++;
        end while (!cmd_end && n < 100);
        check("t4_cmd_end", cmd_end, 1);
        check("t4_wait_cycles", w, T);
        read_chk("t4_res0", 6'h09, 8'h00);
        read_chk("t4_res1", 6'h0A, 8'h00);
        read_chk("t4_res2", 6'h0B, 8'hC0);
        read_chk("t4_res3", 6'h0C, 8'h7F);
        read_chk("t4_status", 6'h0D, 8'h0A);
        ack();

        // 5: reset mid-operation, late core_done
        core_respond = 1; core_lat = 6; core_resp = 32'hDEAD_BEEF;
        host_write(6'h08, 8'(op_add));
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_core_start", core_start, 0);
        check("t5_cmd_end", cmd_end, 0);
        check("t5_core_a", core_a, 0);
        repeat (2) @(posedge clk);
        #2 arst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t5_late_done_cmd_end", cmd_end, 0);
        check("t5_late_done_busy", busy, 0);
        read_chk("t5_unmapped", 6'h20, 8'h00);
        read_chk("t5_res0", 6'h09, 8'h00);

        // 6: wr held low three cycles -> exactly one launch
        core_respond = 1; core_lat = 2; core_resp = 32'h0000_0001;
        s0 = starts;
        @(posedge clk);
        #2 cs = 1'b0; wr = 1'b0; addr = 6'h08; databus_in = 8'(op_mul);
        repeat (3) @(posedge clk);
        #2 cs = 1'b1; wr = 1'b1;
        wait_end("t6_done", 100);
        repeat (4) @(posedge clk);
        check("t6_one_start", starts - s0, 1);
        read_chk("t6_status", 6'h0D, 8'h02);
        ack();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
